// File: rtl/id_pkg.sv
// Shared decode definitions for the ARM ID stage.
// Control bundle, opcode tables, condition codes, decode helpers.
package id_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] ins);
    ctrl_t      c;
    logic [3:0] op;
    logic       s;
    c  = '0;
    op = ins[24:21];
    s  = ins[20];
    unique case (ins[27:26])
      MODE_DP: begin
        c.s     = s;
        c.wb_en = 1'b1;
        case (op)
          OP_MOV: c.exe_cmd = CMD_MOV;
          OP_MVN: c.exe_cmd = CMD_MVN;
          OP_ADD: c.exe_cmd = CMD_ADD;
          OP_ADC: c.exe_cmd = CMD_ADC;
          OP_SUB: c.exe_cmd = CMD_SUB;
          OP_SBC: c.exe_cmd = CMD_SBC;
          OP_AND: c.exe_cmd = CMD_AND;
          OP_ORR: c.exe_cmd = CMD_ORR;
          OP_EOR: c.exe_cmd = CMD_EOR;
          OP_CMP: begin
            c.exe_cmd = CMD_SUB;
            c.wb_en   = 1'b0;
          end
          OP_TST: begin
            c.exe_cmd = CMD_AND;
            c.wb_en   = 1'b0;
          end
          default: c = '0;
        endcase
      end
      MODE_MEM: begin
        c.exe_cmd  = CMD_ADD;
        c.wb_en    = s;
        c.mem_r_en = s;
        c.mem_w_en = ~s;
      end
      MODE_BR: c.b = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic cond_pass(
    input logic [3:0] cc,
    input logic [3:0] sr
  );
    logic n, z, c, v, p;
    n = sr[FLAG_N];
    z = sr[FLAG_Z];
    c = sr[FLAG_C];
    v = sr[FLAG_V];
    unique case (cc)
      CC_EQ:   p = z;
      CC_NE:   p = ~z;
      CC_CS:   p = c;
      CC_CC:   p = ~c;
      CC_MI:   p = n;
      CC_PL:   p = ~n;
      CC_VS:   p = v;
      CC_VC:   p = ~v;
      CC_HI:   p = c & ~z;
      CC_LS:   p = ~c | z;
      CC_GE:   p = (n == v);
      CC_LT:   p = (n != v);
      CC_GT:   p = ~z & (n == v);
      CC_LE:   p = z | (n != v);
      CC_AL:   p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF/ID -> ID and ID/EX -> EXE handshake bundle.
// master = surrounding pipeline, slave = the ID stage.
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     Instruction;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_valid, Instruction, in_pc, out_ready,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, Instruction, in_pc, out_ready,
    output in_ready, out_valid
  );
endinterface

// File: rtl/id_regfile.sv
// Architectural register file, 1 write / 2 async read ports.
// ID_WB_BYPASS_EN: reads see a same-cycle WB write.
module id_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 16,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RW-1:0]   raddr1,
  input  logic [RW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [NREGS];

  // write port, whole file cleared on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign rdata1 = (we && waddr == raddr1) ? wdata : mem[raddr1];
  assign rdata2 = (we && waddr == raddr2) ? wdata : mem[raddr2];
`else
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// ARM decode stage with its own ID/EX register and handshake.
// ID_WB_BYPASS_EN enables WB write-through in id_regfile.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              NREGS        = 16,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0,
  localparam int             RW           = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  id_stage_pipe_if.slave  bus,
  input  logic [3:0]      SR,
  input  logic            hazard,
  input  logic            flush,
  input  logic            writeBackEn,
  input  logic [RW-1:0]   Dest_wb,
  input  logic [XLEN-1:0] Result_WB,
  output logic            WB_EN,
  output logic            MEM_R_EN,
  output logic            MEM_W_EN,
  output logic            B,
  output logic            S,
  output logic [3:0]      EXE_CMD,
  output logic [XLEN-1:0] Val_Rn,
  output logic [XLEN-1:0] Val_Rm,
  output logic            imm,
  output logic [11:0]     Shift_operand,
  output logic [23:0]     Signed_imm_24,
  output logic [RW-1:0]   Dest,
  output logic [XLEN-1:0] out_pc,
  output logic [RW-1:0]   src1,
  output logic [RW-1:0]   src2,
  output logic            Two_src
);

  ctrl_t           ctrl_dec;
  ctrl_t           ctrl_q;
  logic            valid_q;
  logic            pass;
  logic            adv;
  logic            accept;
  logic            take;
  logic [XLEN-1:0] rn_val;
  logic [XLEN-1:0] rm_val;
  logic [31:0]     ins;

  assign ins      = bus.Instruction;
  assign ctrl_dec = decode(ins);
  assign pass     = cond_pass(ins[31:28], SR);

  assign adv          = ~valid_q | bus.out_ready;
  assign bus.in_ready = adv & ~hazard & ~flush;
  assign accept       = bus.in_valid & bus.in_ready;
  assign take         = accept & pass;

  assign src1    = ins[16 +: RW];
  assign src2    = ctrl_dec.mem_w_en ? ins[12 +: RW]
                                     : ins[0 +: RW];
  assign Two_src = ctrl_dec.mem_w_en | ~ins[25];

  id_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (writeBackEn),
    .waddr  (Dest_wb),
    .wdata  (Result_WB),
    .raddr1 (src1),
    .raddr2 (src2),
    .rdata1 (rn_val),
    .rdata2 (rm_val)
  );

  // valid + control: flush kills, bubbles carry zero control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (adv) begin
      valid_q <= take;
      ctrl_q  <= take ? ctrl_dec : '0;
    end
  end

  // data fields load whenever the register advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Val_Rn        <= '0;
      Val_Rm        <= '0;
      imm           <= 1'b0;
      Shift_operand <= '0;
      Signed_imm_24 <= '0;
      Dest          <= '0;
      out_pc        <= RESET_PC_TAG;
    end else if (!flush && adv) begin
      Val_Rn        <= rn_val;
      Val_Rm        <= rm_val;
      imm           <= ins[25];
      Shift_operand <= ins[11:0];
      Signed_imm_24 <= ins[23:0];
      Dest          <= ins[12 +: RW];
      out_pc        <= bus.in_pc;
    end
  end

  assign bus.out_valid = valid_q;
  assign WB_EN         = ctrl_q.wb_en;
  assign MEM_R_EN      = ctrl_q.mem_r_en;
  assign MEM_W_EN      = ctrl_q.mem_w_en;
  assign B             = ctrl_q.b;
  assign S             = ctrl_q.s;
  assign EXE_CMD       = ctrl_q.exe_cmd;

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised ARM decode stage with its own ID/EX pipeline register.
- Decodes the instruction, evaluates the condition against the status flags and reads the register file (contained in the block).
- Registers decoded fields toward EXE under a valid/ready handshake, with stall on hazard or back-pressure and flush on a taken branch.
- Sits between the IF/ID register and the EXE stage; replaces the combinational decode-only stage.

Parameters:
- XLEN, 32, datapath width of register values and Result_WB.
- NREGS, 16, number of architectural registers; index width RW = $clog2(NREGS); must be a power of two ≤ 16.
- RESET_PC_TAG, 0, value loaded into out_pc on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- Instruction  in  32  ARM instruction word.
- in_pc  in  XLEN  PC+4 of the instruction.
- SR  in  4  status flags {N,Z,C,V}.
- hazard  in  1  data hazard from the hazard unit; forces a bubble.
- flush  in  1  branch taken in EXE; kill the current input and the ID/EX contents.
- writeBackEn  in  1  WB register write enable.
- Dest_wb  in  RW  WB destination index.
- Result_WB  in  XLEN  WB data.
- out_valid  out  1  ID/EX holds a valid, non-suppressed operation.
- out_ready  in  1  EXE accepts ID/EX this cycle.
- WB_EN, MEM_R_EN, MEM_W_EN, B, S  out  1 each  registered control bits.
- EXE_CMD  out  4  registered ALU command.
- Val_Rn, Val_Rm  out  XLEN  registered operand values.
- imm  out  1  Instruction[25].
- Shift_operand  out  12  Instruction[11:0].
- Signed_imm_24  out  24  Instruction[23:0].
- Dest  out  RW  Instruction[15:12].
- out_pc  out  XLEN  registered in_pc.
- src1, src2  out  RW  combinational source indices of the current input, for the hazard unit.
- Two_src  out  1  combinational: MEM_W_EN_decoded | ~Instruction[25].

Behaviour:
- Reset (rst=0, async):
  - Clears every registered output and out_valid.
  - out_pc = RESET_PC_TAG.
  - Register file cleared to 0.
- Decode: mode = Instruction[27:26], opcode = Instruction[24:21], s = Instruction[20].
  - DP (mode 00): WB_EN=1 except CMP and TST. EXE_CMD: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, CMP 0100, TST 0110. S = s.
  - MEM (mode 01), s=1: LDR, with WB_EN=1, MEM_R_EN=1, EXE_CMD=0010.
  - MEM (mode 01), s=0: STR, with MEM_W_EN=1, EXE_CMD=0010.
  - BR (mode 10): B=1.
  - Unknown encodings decode to all-zero control.
- Condition: cond = Instruction[31:28], standard ARM EQ..AL (1110). 1111 counts as fail.
- Sources:
  - src1 = Rn = Instruction[19:16].
  - src2 = Instruction[15:12] for a store, else Rm = Instruction[3:0].
  - Indices are truncated to RW bits.
- Advance: adv = ~out_valid | out_ready.
  - in_ready = adv & ~hazard.
  - Accept when in_valid & in_ready.
- Each rising edge, in priority order:
  1. flush=1: out_valid←0 and all control bits←0. The input is not accepted (in_ready forced 0).
  2. Else if adv: the ID/EX register loads the decoded fields.
     - out_valid ← accept & cond_pass.
     - Control bits are zeroed if not (accept & cond_pass).
     - Data fields load regardless.
  3. Else (stall): hold all registered outputs.
- Condition-failed and hazard bubbles produce out_valid=0 with zero control. A bubble has latency 1.
- Latency: an accepted instruction appears on the outputs 1 cycle after acceptance.
- Register file:
  - NREGS×XLEN, written on the rising edge when writeBackEn.
  - Two asynchronous read ports.
- Simultaneous hazard and flush: flush wins.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
  - Defined: if writeBackEn & Dest_wb == read index, the read port returns Result_WB in the same cycle (write-through).
  - Undefined: the read returns the stored value; the hazard unit must cover the WB distance.

Decomposition:
- Package id_pkg holds:
  - mode constants;
  - opcode and EXE_CMD localparams;
  - condition code constants;
  - flag bit positions N=3, Z=2, C=1, V=0;
  - a packed struct for the 9 control bits.
- One sub-module: id_regfile (parametrised XLEN/NREGS, holds the bypass ifdef).
- Decode and condition check are functions in id_pkg.

Test Plan:
- Reset mid-run: rst low while out_valid=1 → out_valid=0, EXE_CMD=0, Val_Rn=0 immediately (async); regfile reads 0.
- ADD R1,R2,R3 (0xE0821003), R2=5, R3=7, out_ready=1 → next cycle out_valid=1, WB_EN=1, EXE_CMD=0010, Val_Rn=5, Val_Rm=7, Dest=1.
- ADDEQ with SR Z=0 → out_valid=0, WB_EN=0; with Z=1 → out_valid=1.
- out_ready=0 for 3 cycles with a valid ID/EX → outputs held, in_ready=0; a new instruction is loaded the cycle after out_ready=1.
- hazard=1 with in_valid=1 → in_ready=0, bubble (out_valid=0) next cycle. hazard and flush together → flush result, ID/EX cleared.
- STR R4,[R0] with writeBackEn=1, Dest_wb=4, Result_WB=0xA5 in the same cycle:
  - with ID_WB_BYPASS_EN, Val_Rm=0xA5;
  - without it, Val_Rm = old R4.
